ex: RTL
=======

# ex

Execute stage of the swt16 pipeline, between decode and the memory stage. It computes the integer ALU result, the data-memory address and the store word for each instruction. All of these are registered toward the memory stage. Most operations complete in one cycle; MUL uses an iterative shift-add unit and back-pressures decode with `out_stall` until the product is ready.

## Interface
- `OPCODE_WIDTH`, 4, width of the ALU operation code
- `DMEM_ADDR_WIDTH`, 12, data-memory address width
- `DMEM_WORD_WIDTH`, 16, data-memory word width
- `IALU_WORD_WIDTH`, 16, operand and result width
- `REG_IDX_WIDTH`, 4, register index width

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  decode presents an instruction
- `in_opcode`  in  OPCODE_WIDTH  ALU operation
- `in_op_a`, `in_op_b`  in  IALU_WORD_WIDTH  operands
- `in_store_data`  in  DMEM_WORD_WIDTH  word to store
- `in_res_reg_idx`  in  REG_IDX_WIDTH  destination register
- `in_act_load_dmem`, `in_act_store_dmem`, `in_act_write_res_to_reg`  in  1 each  control flags
- `out_stall`  out  1  decode must hold its current instruction
- `out_act_load_dmem`, `out_act_store_dmem`, `out_act_write_res_to_reg`  out  1 each  registered flags
- `out_mem_rd_addr`, `out_mem_wr_addr`  out  DMEM_ADDR_WIDTH  registered address
- `out_mem_wr_word`  out  DMEM_WORD_WIDTH  registered store word
- `out_res`  out  IALU_WORD_WIDTH  registered ALU result
- `out_res_reg_idx`  out  REG_IDX_WIDTH  registered destination

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SHL, 6 SHR (logical), 7 SRA; shift amount is `in_op_b[3:0]`
  - 8 SLT (signed; result 1 or 0)
  - 9 MUL (low 16 bits of the product)
  - 10 PASSB (result = `op_b`)
  - 11–15 produce 0
- Arithmetic wraps modulo 2^16; carries are discarded.
- Address: `(in_op_a + in_op_b)[DMEM_ADDR_WIDTH-1:0]`, driven on both `out_mem_rd_addr` and `out_mem_wr_addr`.
- Store word: `in_store_data` passes through to `out_mem_wr_word`.
- Consume rule: an instruction is consumed on a rising edge where `in_valid=1` and `out_stall=0`. On that edge all outputs load the new values.
- Bubble rule: on any other edge the three `out_act_*` flags load 0. All other outputs hold their values.
- MUL state machine:
  - IDLE: if `in_valid` and opcode 9, latch the operands, clear the 4-bit counter and go to BUSY. Otherwise stay in IDLE.
  - BUSY: each cycle, if `b[cnt]` is set, add `a<<cnt` into the accumulator, then increment `cnt`. At `cnt=15`, go to DONE after that iteration.
  - DONE: the held MUL instruction is consumed with `out_res` = accumulator; return to IDLE.
- `out_stall` is combinational: `(IDLE & in_valid & opcode==9) | BUSY`. It is 0 in DONE and whenever `reset` is low.

## Timing
- Reset (asynchronous, `reset` low): every output is 0, state is IDLE, counter and accumulator are 0. Reset asserted mid-MUL abandons the multiply; no output is produced.
- Single-cycle op consumed at edge E: results are visible immediately after E.
- MUL first presented in cycle N:
  - `out_stall` is high in cycles N through N+16 (1 IDLE cycle plus 16 BUSY cycles).
  - Cycle N+17 is DONE; `out_stall` is low.
  - The result is visible from cycle N+18.
  - Each MUL costs 17 lost issue slots and produces 17 bubbles.
- Back-to-back MULs: the second MUL is seen in IDLE in cycle N+18 and starts a new sequence.
- While stalled, the memory stage sees only bubbles. A store is never issued twice.
- `in_valid=0` in IDLE: `out_stall=0`; a bubble is loaded.
- Inputs presented in DONE must equal those latched in cycle N (decode holds them). The multiply uses the latched copies.

## Test plan
- Reset: drive `reset` low mid-operation → all outputs 0 and `out_stall` 0 asynchronously, before the next clock edge.
- ADD with a=0xFFFF, b=0x0002, write flag set, idx 5 → next cycle `out_res`=0x0001, `out_act_write_res_to_reg`=1, `out_res_reg_idx`=5.
- Shifts and compare:
  - SRA with a=0x8000, b=0x0003 → `out_res`=0xF000.
  - SLT with a=0xFFFF, b=0x0001 → `out_res`=1.
  - Opcode 13 → `out_res`=0.
- Store with a=0x0FF0, b=0x0020, `in_store_data`=0xBEEF → address 0x010 (wrapped), `out_mem_wr_word`=0xBEEF, `out_act_store_dmem`=1 for exactly one cycle.
- MUL with a=0x0123, b=0x0456 presented in cycle N:
  - `out_stall` high for exactly 17 cycles.
  - `out_res`=0xEDC2 in cycle N+18.
  - `out_act_*` are 0 in cycles N+1 through N+17.
  - A following ADD issues immediately after.
- Reset pulse during BUSY, then MUL 0x0003×0x0005 → no stale result appears; the product 0x000F arrives on schedule.

Source files
------------

// File: rtl/ex.sv
// rtl/ex.sv - swt16 execute stage: integer ALU, address/store-word generation, iterative MUL
//
// Ports:
//   clock, reset              rising-edge clock, asynchronous active-low reset
//   in_valid, in_opcode       instruction from decode and its ALU operation
//   in_op_a, in_op_b          operands (address = low bits of their sum)
//   in_store_data             word to store, passed through
//   in_res_reg_idx            destination register index
//   in_act_*                  load / store / register-write control flags
//   out_stall                 decode must hold its instruction (combinational)
//   out_act_*                 registered flags toward the memory stage (0 on bubbles)
//   out_mem_rd_addr/wr_addr   registered data-memory address
//   out_mem_wr_word           registered store word
//   out_res, out_res_reg_idx  registered ALU result and destination
module ex #(
  parameter int OPCODE_WIDTH    = 4,
  parameter int DMEM_ADDR_WIDTH = 12,
  parameter int DMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [OPCODE_WIDTH-1:0]    in_opcode,
  input  logic [IALU_WORD_WIDTH-1:0] in_op_a,
  input  logic [IALU_WORD_WIDTH-1:0] in_op_b,
  input  logic [DMEM_WORD_WIDTH-1:0] in_store_data,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  output logic                       out_stall,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_mem_wr_addr,
  output logic [DMEM_WORD_WIDTH-1:0] out_mem_wr_word,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx
);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB   = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR    = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR   = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL   = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR   = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SRA   = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_SLT   = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_PASSB = OPCODE_WIDTH'(10);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                     state;
  logic [3:0]                 cnt;
  logic [IALU_WORD_WIDTH-1:0] acc;
  logic [IALU_WORD_WIDTH-1:0] mul_a;
  logic [IALU_WORD_WIDTH-1:0] mul_b;

  logic                       is_mul;
  logic                       consume;
  logic [IALU_WORD_WIDTH-1:0] sum;
  logic [IALU_WORD_WIDTH-1:0] alu_res;
  logic [3:0]                 shamt;

  assign is_mul  = (in_opcode == OP_MUL);
  // Gated by reset so decode is released the instant reset asserts.
  assign out_stall = reset & (((state == IDLE) & in_valid & is_mul) | (state == BUSY));
  assign consume = in_valid & ~out_stall;
  assign sum     = in_op_a + in_op_b;
  assign shamt   = in_op_b[3:0];

  always_comb begin
    alu_res = '0;
    case (in_opcode)
      OP_ADD:   alu_res = sum;
      OP_SUB:   alu_res = in_op_a - in_op_b;
      OP_AND:   alu_res = in_op_a & in_op_b;
      OP_OR:    alu_res = in_op_a | in_op_b;
      OP_XOR:   alu_res = in_op_a ^ in_op_b;
      OP_SHL:   alu_res = in_op_a << shamt;
      OP_SHR:   alu_res = in_op_a >> shamt;
      OP_SRA:   alu_res = $signed(in_op_a) >>> shamt;
      OP_SLT:   alu_res = {{(IALU_WORD_WIDTH-1){1'b0}}, ($signed(in_op_a) < $signed(in_op_b))};
      // A MUL is only ever consumed from DONE, where acc holds the finished product.
      OP_MUL:   alu_res = acc;
      OP_PASSB: alu_res = in_op_b;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                    <= IDLE;
      cnt                      <= '0;
      acc                      <= '0;
      mul_a                    <= '0;
      mul_b                    <= '0;
      out_act_load_dmem        <= 1'b0;
      out_act_store_dmem       <= 1'b0;
      out_act_write_res_to_reg <= 1'b0;
      out_mem_rd_addr          <= '0;
      out_mem_wr_addr          <= '0;
      out_mem_wr_word          <= '0;
      out_res                  <= '0;
      out_res_reg_idx          <= '0;
    end else begin
      if (consume) begin
        out_act_load_dmem        <= in_act_load_dmem;
        out_act_store_dmem       <= in_act_store_dmem;
        out_act_write_res_to_reg <= in_act_write_res_to_reg;
        out_mem_rd_addr          <= sum[DMEM_ADDR_WIDTH-1:0];
        out_mem_wr_addr          <= sum[DMEM_ADDR_WIDTH-1:0];
        out_mem_wr_word          <= in_store_data;
        out_res                  <= alu_res;
        out_res_reg_idx          <= in_res_reg_idx;
      end else begin
        // Bubble: data outputs hold, only the action flags drop.
        out_act_load_dmem        <= 1'b0;
        out_act_store_dmem       <= 1'b0;
        out_act_write_res_to_reg <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (in_valid && is_mul) begin
            mul_a <= in_op_a;
            mul_b <= in_op_b;
            cnt   <= '0;
            acc   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (mul_b[cnt]) begin
            acc <= acc + (mul_a << cnt);
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
